// File: rtl/mem_stage_ctrl_if.sv
// Signal bundle between the MEM-stage controller (master) and its pipeline/memory side (slave).
// mem_err is present only when MEM_TIMEOUT_EN is defined.
interface mem_stage_ctrl_if;
    logic        valid_in;
    logic [3:0]  opcode;
    logic        mem_read;
    logic        mem_write;
    logic        byte_op;
    logic [15:0] alu_addr;
    logic [15:0] store_data;
    logic [15:0] mem_rdata;
    logic        mem_resp;
    logic [15:0] mem_address;
    logic        mem_read_o;
    logic        mem_write_o;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_wdata;
    logic        stall;
    logic        done;
    logic [15:0] data_out;
`ifdef MEM_TIMEOUT_EN
    logic        mem_err;

    modport master (
        input  valid_in, opcode, mem_read, mem_write, byte_op, alu_addr, store_data,
               mem_rdata, mem_resp,
        output mem_address, mem_read_o, mem_write_o, mem_byte_enable, mem_wdata,
               stall, done, data_out, mem_err
    );
    modport slave (
        output valid_in, opcode, mem_read, mem_write, byte_op, alu_addr, store_data,
               mem_rdata, mem_resp,
        input  mem_address, mem_read_o, mem_write_o, mem_byte_enable, mem_wdata,
               stall, done, data_out, mem_err
    );
`else
    modport master (
        input  valid_in, opcode, mem_read, mem_write, byte_op, alu_addr, store_data,
               mem_rdata, mem_resp,
        output mem_address, mem_read_o, mem_write_o, mem_byte_enable, mem_wdata,
               stall, done, data_out
    );
    modport slave (
        output valid_in, opcode, mem_read, mem_write, byte_op, alu_addr, store_data,
               mem_rdata, mem_resp,
        input  mem_address, mem_read_o, mem_write_o, mem_byte_enable, mem_wdata,
               stall, done, data_out
    );
`endif
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage load/store controller: word, byte and indirect (LDI/STI) accesses with stall/done handshake.
// Optional MEM_TIMEOUT_EN: 255-cycle request timeout that forces DONE and sets sticky mem_err.
module mem_stage_ctrl (
    input  logic             clk,
    input  logic             reset,
    mem_stage_ctrl_if.master bus
);
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    typedef enum logic [1:0] {IDLE, IND_RD, ACC, DONE} state_t;

    typedef struct packed {
        logic [3:0]  op;
        logic        rd;
        logic        wr;
        logic        bop;
        logic [15:0] addr;
        logic [15:0] data;
    } req_t;

    state_t      state, state_n;
    req_t        lat;
    logic [15:0] dout;
    logic        memop;
    logic        byte_acc;
    logic        tout;
    logic [15:0] rdata_ld;
    logic        stall, done, rd_o, wr_o;
    logic [1:0]  be_o;
    logic [15:0] addr_o, wdata_o;

    assign memop    = bus.valid_in & (bus.mem_read | bus.mem_write);
    // TRAP vectors are always fetched as whole words
    assign byte_acc = lat.bop & (lat.op != OP_TRAP);

    always_comb begin
        rdata_ld = bus.mem_rdata;
        if (byte_acc) begin
            if (lat.addr[0])
                rdata_ld = {{8{bus.mem_rdata[15]}}, bus.mem_rdata[15:8]};
            else
                rdata_ld = {{8{bus.mem_rdata[7]}}, bus.mem_rdata[7:0]};
        end
    end

`ifdef MEM_TIMEOUT_EN
    logic [7:0] tcnt;
    logic       err;
    logic       active;

    assign active = (state == IND_RD) || (state == ACC);
    // tcnt reads 254 during the 255th cycle a request has been outstanding
    assign tout   = (tcnt == 8'd254);

    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt <= '0;
            err  <= 1'b0;
        end else begin
            if (state_n != state)
                tcnt <= '0;
            else if (active)
                tcnt <= tcnt + 8'd1;
            if (active && tout && !bus.mem_resp)
                err <= 1'b1;
        end
    end

    assign bus.mem_err = err;
`else
    assign tout = 1'b0;
`endif

    always_comb begin
        state_n = state;
        stall   = 1'b0;
        done    = 1'b0;
        rd_o    = 1'b0;
        wr_o    = 1'b0;
        be_o    = 2'b00;
        addr_o  = '0;
        wdata_o = '0;
        case (state)
            IDLE: begin
                stall = memop;
                done  = bus.valid_in & ~memop;
                if (memop)
                    state_n = (bus.opcode == OP_LDI || bus.opcode == OP_STI) ? IND_RD : ACC;
            end
            IND_RD: begin
                // pointer fetch is always a word read
                stall   = 1'b1;
                rd_o    = 1'b1;
                be_o    = 2'b11;
                addr_o  = {lat.addr[15:1], 1'b0};
                wdata_o = lat.data;
                if (bus.mem_resp)
                    state_n = ACC;
                else if (tout)
                    state_n = DONE;
            end
            ACC: begin
                stall = 1'b1;
                rd_o  = lat.rd;
                wr_o  = lat.wr & ~lat.rd;
                if (byte_acc) begin
                    addr_o  = lat.addr;
                    be_o    = lat.addr[0] ? 2'b10 : 2'b01;
                    wdata_o = {2{lat.data[7:0]}};
                end else begin
                    addr_o  = {lat.addr[15:1], 1'b0};
                    be_o    = 2'b11;
                    wdata_o = lat.data;
                end
                if (bus.mem_resp || tout)
                    state_n = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            lat   <= '0;
            dout  <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (memop)
                        lat <= '{op: bus.opcode, rd: bus.mem_read, wr: bus.mem_write,
                                 bop: bus.byte_op, addr: bus.alu_addr, data: bus.store_data};
                end
                IND_RD: begin
                    if (bus.mem_resp)
                        lat.addr <= bus.mem_rdata;
                end
                ACC: begin
                    if (bus.mem_resp && lat.rd)
                        dout <= rdata_ld;
                end
                default: ;
            endcase
        end
    end

    assign bus.stall           = stall;
    assign bus.done            = done;
    assign bus.mem_read_o      = rd_o;
    assign bus.mem_write_o     = wr_o;
    assign bus.mem_byte_enable = be_o;
    assign bus.mem_address     = addr_o;
    assign bus.mem_wdata       = wdata_o;
    assign bus.data_out        = dout;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomized bench for mem_stage_ctrl: a behavioural memory answers requests, and a
// spec-level model predicts addresses, enables, write data, load results and handshake counts.
module tb_mem_stage_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_stage_ctrl_if bus ();
    mem_stage_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    int pass_cnt = 0;
    int total    = 0;

    // observations recorded by run_mem
    int          n_req, stall_cnt, done_cnt, unstable, both, timed_out;
    int          req_cyc [2];
    logic [15:0] o_addr  [2];
    logic [15:0] o_wd    [2];
    logic [1:0]  o_be    [2];
    logic        o_rd    [2];
    logic        o_wr    [2];
    logic        c0_stall, c0_done;
    logic [15:0] ref_dout;

    function automatic logic [15:0] sext(input logic [7:0] b);
        return {{8{b[7]}}, b};
    endfunction

    // Presents one ipacket, then plays memory: request k answers after lat[k] cycles (0 = never).
    task automatic run_mem(input logic [3:0] op, input logic rd, input logic wr, input logic bop,
                           input logic [15:0] addr, input logic [15:0] sd,
                           input int lat0, input logic [15:0] d0,
                           input int lat1, input logic [15:0] d1);
        int k;
        int cyc;
        int lat;
        n_req = 0; stall_cnt = 0; done_cnt = 0; unstable = 0; both = 0; timed_out = 0;
        req_cyc[0] = 0; req_cyc[1] = 0;
        @(posedge clk); #1;
        bus.valid_in = 1'b1; bus.opcode = op; bus.mem_read = rd; bus.mem_write = wr;
        bus.byte_op = bop; bus.alu_addr = addr; bus.store_data = sd; bus.mem_resp = 1'b0;
        #1;
        c0_stall = bus.stall;
        c0_done  = bus.done;
        if (bus.stall) stall_cnt++;
        k = -1; cyc = 0;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            // upstream noise while stalled must be ignored
            bus.valid_in   = 1'($urandom);
            bus.opcode     = 4'($urandom);
            bus.mem_read   = 1'($urandom);
            bus.mem_write  = 1'($urandom);
            bus.byte_op    = 1'($urandom);
            bus.alu_addr   = 16'($urandom);
            bus.store_data = 16'($urandom);
            bus.mem_rdata  = 16'($urandom);
            bus.mem_resp   = 1'b0;
            #1;
            if (bus.done) begin
                done_cnt++;
                bus.valid_in = 1'b0;
                n_req = k + 1;
                return;
            end
            if (bus.stall) stall_cnt++;
            if (bus.mem_read_o && bus.mem_write_o) both++;
            if (bus.mem_read_o || bus.mem_write_o) begin
                if (cyc == 0) begin
                    k++;
                    if (k < 2) begin
                        o_addr[k] = bus.mem_address; o_be[k] = bus.mem_byte_enable;
                        o_wd[k] = bus.mem_wdata; o_rd[k] = bus.mem_read_o; o_wr[k] = bus.mem_write_o;
                    end
                end else if (k < 2 && (o_addr[k] !== bus.mem_address || o_be[k] !== bus.mem_byte_enable ||
                             o_rd[k] !== bus.mem_read_o || o_wr[k] !== bus.mem_write_o ||
                             o_wd[k] !== bus.mem_wdata)) begin
                    unstable++;
                end
                cyc++;
                if (k < 2) req_cyc[k] = cyc;
                lat = (k == 0) ? lat0 : lat1;
                if (cyc == lat) begin
                    bus.mem_resp  = 1'b1;
                    bus.mem_rdata = (k == 0) ? d0 : d1;
                    cyc = 0;
                end
            end
        end
        n_req = k + 1;
        timed_out = 1;
        bus.valid_in = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.valid_in = 1'b0; bus.opcode = 4'd0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        bus.byte_op = 1'b0; bus.alu_addr = 16'h0; bus.store_data = 16'h0;
        bus.mem_rdata = 16'hDEAD; bus.mem_resp = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bus.mem_read_o, bus.mem_write_o, bus.done, bus.stall, bus.mem_byte_enable} !== 6'b0) begin
            $display("FAIL reset_ctrl: got rd=%b wr=%b done=%b stall=%b be=%b, want all 0",
                     bus.mem_read_o, bus.mem_write_o, bus.done, bus.stall, bus.mem_byte_enable);
        end else pass_cnt++;
        total++;
        if ({bus.mem_address, bus.mem_wdata, bus.data_out} !== 48'h0) begin
            $display("FAIL reset_data: got addr=%h wdata=%h dout=%h, want 0000",
                     bus.mem_address, bus.mem_wdata, bus.data_out);
        end else pass_cnt++;
`ifdef MEM_TIMEOUT_EN
        total++;
        if (bus.mem_err !== 1'b0) $display("FAIL reset_err: got %b want 0", bus.mem_err);
        else pass_cnt++;
`endif
        bus.mem_resp = 1'b0;
        reset = 1'b0;
        ref_dout = 16'h0;
    endtask

    task automatic test_ldr;
        run_mem(4'b0110, 1'b1, 1'b0, 1'b0, 16'h1235, 16'h0, 3, 16'hBEEF, 0, 16'h0);
        ref_dout = 16'hBEEF;
        total++;
        if ({o_addr[0], o_be[0], o_rd[0], o_wr[0]} !== {16'h1234, 2'b11, 1'b1, 1'b0})
            $display("FAIL ldr_req: got addr=%h be=%b rd=%b wr=%b, want 1234 11 1 0",
                     o_addr[0], o_be[0], o_rd[0], o_wr[0]);
        else pass_cnt++;
        total++;
        if (bus.data_out !== 16'hBEEF) $display("FAIL ldr_data: got %h want BEEF", bus.data_out);
        else pass_cnt++;
        total++;
        if (stall_cnt !== 4 || done_cnt !== 1 || c0_done !== 1'b0 || timed_out !== 0)
            $display("FAIL ldr_handshake: got stall=%0d done=%0d c0_done=%b to=%0d, want 4 1 0 0",
                     stall_cnt, done_cnt, c0_done, timed_out);
        else pass_cnt++;
        @(posedge clk); #2;
        total++;
        if (bus.done !== 1'b0) $display("FAIL ldr_done_width: done still %b a cycle later, want 0", bus.done);
        else pass_cnt++;
    endtask

    task automatic test_ldb;
        run_mem(4'b0010, 1'b1, 1'b0, 1'b1, 16'h2001, 16'h0, 2, 16'h80FF, 0, 16'h0);
        ref_dout = 16'hFF80;
        total++;
        if (o_addr[0] !== 16'h2001 || o_be[0] !== 2'b10)
            $display("FAIL ldb_req: got addr=%h be=%b, want 2001 10", o_addr[0], o_be[0]);
        else pass_cnt++;
        total++;
        if (bus.data_out !== 16'hFF80) $display("FAIL ldb_data: got %h want FF80", bus.data_out);
        else pass_cnt++;
    endtask

    task automatic test_stb;
        run_mem(4'b0011, 1'b0, 1'b1, 1'b1, 16'h3000, 16'h12AB, 1, 16'h5555, 0, 16'h0);
        total++;
        if ({o_rd[0], o_wr[0], o_be[0], o_wd[0], o_addr[0]} !== {1'b0, 1'b1, 2'b01, 16'hABAB, 16'h3000})
            $display("FAIL stb_req: got rd=%b wr=%b be=%b wdata=%h addr=%h, want 0 1 01 ABAB 3000",
                     o_rd[0], o_wr[0], o_be[0], o_wd[0], o_addr[0]);
        else pass_cnt++;
        total++;
        if (bus.data_out !== ref_dout) $display("FAIL stb_dout_hold: got %h want %h", bus.data_out, ref_dout);
        else pass_cnt++;
    endtask

    task automatic test_ldi;
        run_mem(4'b1010, 1'b1, 1'b0, 1'b0, 16'h4000, 16'h0, 2, 16'h5002, 3, 16'h7777);
        ref_dout = 16'h7777;
        total++;
        if (n_req !== 2 || o_addr[0] !== 16'h4000 || o_addr[1] !== 16'h5002 || o_rd[1] !== 1'b1)
            $display("FAIL ldi_reqs: got n=%0d a0=%h a1=%h rd1=%b, want 2 4000 5002 1",
                     n_req, o_addr[0], o_addr[1], o_rd[1]);
        else pass_cnt++;
        total++;
        if (bus.data_out !== 16'h7777 || stall_cnt !== 6)
            $display("FAIL ldi_data: got dout=%h stall=%0d, want 7777 6", bus.data_out, stall_cnt);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        int dn;
        @(posedge clk); #1;
        bus.valid_in = 1'b1; bus.opcode = 4'b0110; bus.mem_read = 1'b1; bus.mem_write = 1'b0;
        bus.byte_op = 1'b0; bus.alu_addr = 16'h0ABC; bus.mem_resp = 1'b0;
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        reset = 1'b1; bus.mem_resp = 1'b1; bus.mem_rdata = 16'h1111;
        @(posedge clk); #1;
        reset = 1'b0; bus.mem_resp = 1'b0;
        #1;
        total++;
        if (bus.mem_read_o !== 1'b0 || bus.done !== 1'b0 || bus.stall !== 1'b0 || bus.data_out !== 16'h0)
            $display("FAIL reset_mid: got rd=%b done=%b stall=%b dout=%h, want 0 0 0 0000",
                     bus.mem_read_o, bus.done, bus.stall, bus.data_out);
        else pass_cnt++;
        ref_dout = 16'h0;
        dn = 0;
        repeat (5) begin
            @(posedge clk); #2;
            if (bus.done || bus.mem_read_o) dn++;
        end
        total++;
        if (dn !== 0) $display("FAIL reset_mid_after: got %0d done/read cycles, want 0", dn);
        else pass_cnt++;
    endtask

    task automatic test_no_memop;
        @(posedge clk); #1;
        bus.valid_in = 1'b1; bus.opcode = 4'b0001; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        #1;
        total++;
        if (bus.done !== 1'b1 || bus.stall !== 1'b0 || bus.mem_read_o !== 1'b0)
            $display("FAIL add_pass: got done=%b stall=%b rd=%b, want 1 0 0", bus.done, bus.stall, bus.mem_read_o);
        else pass_cnt++;
        bus.valid_in = 1'b0;
        #1;
        total++;
        if (bus.done !== 1'b0) $display("FAIL idle_done: got %b want 0", bus.done);
        else pass_cnt++;
        // stray responses while idle must not load data
        bus.mem_resp = 1'b1; bus.mem_rdata = 16'h4321;
        repeat (2) @(posedge clk);
        #1;
        bus.mem_resp = 1'b0;
        #1;
        total++;
        if (bus.data_out !== ref_dout || bus.done !== 1'b0)
            $display("FAIL resp_ignored: got dout=%h done=%b, want %h 0", bus.data_out, bus.done, ref_dout);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        run_mem(4'b0111, 1'b0, 1'b1, 1'b0, 16'h0101, 16'hCAFE, 1, 16'h0, 0, 16'h0);
        total++;
        if (o_addr[0] !== 16'h0100 || o_be[0] !== 2'b11 || o_wd[0] !== 16'hCAFE || o_wr[0] !== 1'b1)
            $display("FAIL b2b_stw: got addr=%h be=%b wdata=%h wr=%b, want 0100 11 CAFE 1",
                     o_addr[0], o_be[0], o_wd[0], o_wr[0]);
        else pass_cnt++;
        run_mem(4'b0010, 1'b1, 1'b0, 1'b1, 16'h0101, 16'h0, 1, 16'hCAFE, 0, 16'h0);
        ref_dout = 16'hFFCA;
        total++;
        if (c0_stall !== 1'b1 || c0_done !== 1'b0 || bus.data_out !== 16'hFFCA)
            $display("FAIL b2b_ldb: got stall0=%b done0=%b dout=%h, want 1 0 FFCA",
                     c0_stall, c0_done, bus.data_out);
        else pass_cnt++;
    endtask

    task automatic test_random;
        logic [3:0]  ops [7] = '{4'd2, 4'd3, 4'd6, 4'd7, 4'd10, 4'd11, 4'd15};
        logic [3:0]  op;
        logic        rd, bop, ind, bacc;
        logic [15:0] addr, sd, d0, d1, ptr, dl, e_addr, e_wd;
        logic [1:0]  e_be;
        int          l0, l1, ai;
        for (int t = 0; t < 40; t++) begin
            op   = ops[$urandom_range(0, 6)];
            rd   = (op == 4'd2 || op == 4'd6 || op == 4'd10 || op == 4'd15);
            bop  = 1'($urandom);
            addr = 16'($urandom); sd = 16'($urandom);
            d0   = 16'($urandom); d1 = 16'($urandom);
            l0   = $urandom_range(1, 4); l1 = $urandom_range(1, 4);
            run_mem(op, rd, ~rd, bop, addr, sd, l0, d0, l1, d1);
            ind  = (op == 4'd10 || op == 4'd11);
            ptr  = ind ? d0 : addr;
            dl   = ind ? d1 : d0;
            ai   = ind ? 1 : 0;
            bacc = bop && (op != 4'd15);
            e_addr = bacc ? ptr : (ptr & 16'hFFFE);
            e_be   = bacc ? (ptr[0] ? 2'b10 : 2'b01) : 2'b11;
            e_wd   = bacc ? {2{sd[7:0]}} : sd;
            if (rd) ref_dout = bacc ? (ptr[0] ? sext(dl[15:8]) : sext(dl[7:0])) : dl;
            total++;
            if (n_req !== ai + 1 || timed_out !== 0 || done_cnt !== 1 ||
                stall_cnt !== 1 + l0 + (ind ? l1 : 0) || c0_stall !== 1'b1)
                $display("FAIL rnd_flow t=%0d op=%h: got n=%0d to=%0d done=%0d stall=%0d s0=%b, want %0d 0 1 %0d 1",
                         t, op, n_req, timed_out, done_cnt, stall_cnt, c0_stall, ai + 1, 1 + l0 + (ind ? l1 : 0));
            else pass_cnt++;
            if (ind) begin
                total++;
                if (o_addr[0] !== (addr & 16'hFFFE) || o_be[0] !== 2'b11 || o_rd[0] !== 1'b1)
                    $display("FAIL rnd_ptr t=%0d: got addr=%h be=%b rd=%b, want %h 11 1",
                             t, o_addr[0], o_be[0], o_rd[0], addr & 16'hFFFE);
                else pass_cnt++;
            end
            total++;
            if (o_addr[ai] !== e_addr || o_be[ai] !== e_be || o_rd[ai] !== rd || o_wr[ai] !== ~rd ||
                (!rd && o_wd[ai] !== e_wd))
                $display("FAIL rnd_acc t=%0d op=%h: got addr=%h be=%b rd=%b wr=%b wd=%h, want %h %b %b %b %h",
                         t, op, o_addr[ai], o_be[ai], o_rd[ai], o_wr[ai], o_wd[ai], e_addr, e_be, rd, ~rd, e_wd);
            else pass_cnt++;
            total++;
            if (bus.data_out !== ref_dout || unstable !== 0 || both !== 0)
                $display("FAIL rnd_data t=%0d: got dout=%h unstable=%0d both=%0d, want %h 0 0",
                         t, bus.data_out, unstable, both, ref_dout);
            else pass_cnt++;
        end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout;
        run_mem(4'b0110, 1'b1, 1'b0, 1'b0, 16'h1000, 16'h0, 0, 16'h0, 0, 16'h0);
        total++;
        if (req_cyc[0] !== 255 || done_cnt !== 1 || bus.mem_err !== 1'b1 || bus.data_out !== ref_dout)
            $display("FAIL timeout: got cycles=%0d done=%0d err=%b dout=%h, want 255 1 1 %h",
                     req_cyc[0], done_cnt, bus.mem_err, bus.data_out, ref_dout);
        else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset;
        test_ldr;
        test_ldb;
        test_stb;
        test_ldi;
        test_no_memop;
        test_back_to_back;
        test_random;
        test_reset_mid;
`ifdef MEM_TIMEOUT_EN
        test_timeout;
`endif
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL have clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have reset, input, 1, synchronous, active-high.
REQ-003 SHALL have valid_in, input, 1, MEM-stage ipacket valid.
REQ-004 SHALL have opcode, input, 4, ipacket opcode field.
REQ-005 SHALL have mem_read / mem_write / byte_op, inputs, 1 each, ipacket control bits.
REQ-006 SHALL have alu_addr, input, 16, effective address from EXE.
REQ-007 SHALL have store_data, input, 16, SR value for stores.
REQ-008 SHALL have mem_rdata, input, 16, and mem_resp, input, 1, memory read data and completion pulse.
REQ-009 SHALL have mem_address, output, 16; mem_read_o / mem_write_o, outputs, 1; mem_byte_enable, output, 2; mem_wdata, output, 16.
REQ-010 SHALL have stall, output, 1, holds upstream pipeline; done, output, 1, MEM result valid; data_out, output, 16, load result.

Function
REQ-011 SHALL implement states IDLE, IND_RD, ACC, DONE.
REQ-012 IDLE: valid_in & (mem_read|mem_write) SHALL latch opcode, address, data, byte_op and go to IND_RD if opcode is 1010 (LDI) or 1011 (STI), else ACC; no memory op -> stay IDLE, stall=0, done=valid_in.
REQ-013 IND_RD: SHALL issue word read at latched address; on mem_resp, SHALL replace latched address with mem_rdata and go to ACC.
REQ-014 ACC: SHALL issue read (mem_read set) or write (mem_write set) at latched address; on mem_resp, SHALL capture load data and go to DONE.
REQ-015 DONE: SHALL assert done for exactly one cycle, stall=0, then return to IDLE.
REQ-016 stall SHALL be combinationally high in IDLE when a memory op is presented, and high throughout IND_RD and ACC.
REQ-017 mem_read_o/mem_write_o SHALL be asserted only in IND_RD/ACC and held stable until mem_resp; never both high.
REQ-018 Word access: mem_address = {addr[15:1],0}, mem_byte_enable = 11, mem_wdata = store_data.
REQ-019 Byte access (byte_op): mem_address = addr unaltered, mem_byte_enable = 01 if addr[0]=0 else 10, mem_wdata = {store_data[7:0], store_data[7:0]}.
REQ-020 LDB data_out SHALL be sign-extension of selected byte (low byte if addr[0]=0, else high byte); word loads pass mem_rdata; TRAP (1111) treated as word read.
REQ-021 data_out SHALL hold its value until next capture; stores leave data_out unchanged.
REQ-022 IND_RD always word access regardless of byte_op.
REQ-023 mem_resp outside IND_RD/ACC SHALL be ignored.
REQ-024 valid_in/control changes while in IND_RD/ACC/DONE SHALL be ignored (latched copy used).

Reset
REQ-025 reset SHALL force IDLE, clear mem_read_o, mem_write_o, done, data_out=0x0000, latched registers=0, mem_byte_enable=00, mem_address=0x0000, mem_wdata=0x0000, timeout counter=0; reset overrides pending mem_resp.
REQ-026 reset mid-access SHALL abandon the transaction; no done pulse follows.

Configuration
REQ-027 MEM_TIMEOUT_EN defined: 8-bit counter SHALL count cycles in IND_RD/ACC, clear on state entry; reaching 255 without mem_resp SHALL drop request, go to DONE, set sticky output mem_err (1 bit, cleared by reset only).
REQ-028 MEM_TIMEOUT_EN undefined: no counter, no mem_err port; controller waits indefinitely.

Verification
REQ-029 LDR alu_addr=0x1235, mem_rdata=0xBEEF, resp after 3 cycles -> mem_address=0x1234, enable=11, data_out=0xBEEF, done 1 cycle, stall 4 cycles.
REQ-030 LDB alu_addr=0x2001, mem_rdata=0x80FF -> enable=10, data_out=0xFF80.
REQ-031 STB alu_addr=0x3000, store_data=0x12AB -> mem_write_o, enable=01, mem_wdata=0xABAB, data_out unchanged.
REQ-032 LDI alu_addr=0x4000, first rdata=0x5002, second rdata=0x7777 -> reads at 0x4000 then 0x5002, data_out=0x7777.
REQ-033 reset asserted in ACC -> next cycle IDLE, mem_read_o=0, done=0; ADD (no mem op) -> done same cycle, stall=0.
REQ-034 (MEM_TIMEOUT_EN) no mem_resp -> request dropped after 255 cycles, mem_err=1, done pulses.
